// File: rtl/sensor_link_pkg.sv
// rtl/sensor_link_pkg.sv - shared state encodings and constants for the sensor request path
//
// Contents:
//   framer_state_t  : request_framer FSM encoding (also exported on debug_state)
//   HOLDOFF_MIN     : smallest holdoff that lets the decoder return to IDLE
//   DHT11_ADDR      : sensor address shared with the request decoder
//   is_replay_state : states in which a frame is being replayed or held off

package sensor_link_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_REQ  = 3'd0,
        ST_WAIT_ADDR = 3'd1,
        ST_ANNOUNCE  = 3'd2,
        ST_SEND_REQ  = 3'd3,
        ST_SEND_ADDR = 3'd4,
        ST_HOLDOFF   = 3'd5
    } framer_state_t;

    localparam int         HOLDOFF_MIN = 2;
    localparam logic [7:0] DHT11_ADDR  = 8'h20;

    // True from the enable pulse through the last holdoff cycle; these are
    // the states where incoming bytes go to the pending buffer.
    function automatic logic is_replay_state(input framer_state_t s);
        return (s == ST_ANNOUNCE) || (s == ST_SEND_REQ) ||
               (s == ST_SEND_ADDR) || (s == ST_HOLDOFF);
    endfunction

endpackage

// File: rtl/request_framer.sv
// rtl/request_framer.sv - collects request/address bytes and replays them to the request decoder
//
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   rx_data, rx_valid  : byte from the UART receiver and its one-cycle strobe
//   rx_error           : one-cycle framing/parity error strobe
//   enable             : one-cycle frame announce pulse to the decoder
//   received_data      : request byte, then address byte, otherwise 8'h00
//   busy               : high from enable through the last holdoff cycle
//   frame_dropped      : one-cycle pulse, partial frame discarded
//   overrun            : one-cycle pulse, byte lost with pending buffer full
//   debug_state        : current FSM state

module request_framer
    import sensor_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       enable,
    output logic [7:0] received_data,
    output logic       busy,
    output logic       frame_dropped,
    output logic       overrun,
    output logic [2:0] debug_state
);

    // A holdoff shorter than the decoder's return-to-IDLE time is clamped up.
    localparam int HOLD_EFF = (HOLDOFF_CYCLES < HOLDOFF_MIN) ? HOLDOFF_MIN : HOLDOFF_CYCLES;
    localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HO_W     = $clog2(HOLD_EFF);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLD_EFF - 1);

    framer_state_t   state_q, state_d;
    logic [7:0]      req_q, req_d;
    logic [7:0]      addr_q, addr_d;
    logic            pend_valid_q, pend_valid_d;
    logic [7:0]      pend_byte_q, pend_byte_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;

    logic            enable_q, enable_d;
    logic [7:0]      received_data_q, received_data_d;
    logic            busy_q, busy_d;
    logic            frame_dropped_q, frame_dropped_d;
    logic            overrun_q, overrun_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_WAIT_REQ;
            req_q           <= 8'h00;
            addr_q          <= 8'h00;
            pend_valid_q    <= 1'b0;
            pend_byte_q     <= 8'h00;
            to_cnt_q        <= '0;
            ho_cnt_q        <= '0;
            enable_q        <= 1'b0;
            received_data_q <= 8'h00;
            busy_q          <= 1'b0;
            frame_dropped_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            addr_q          <= addr_d;
            pend_valid_q    <= pend_valid_d;
            pend_byte_q     <= pend_byte_d;
            to_cnt_q        <= to_cnt_d;
            ho_cnt_q        <= ho_cnt_d;
            enable_q        <= enable_d;
            received_data_q <= received_data_d;
            busy_q          <= busy_d;
            frame_dropped_q <= frame_dropped_d;
            overrun_q       <= overrun_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        addr_d          = addr_q;
        pend_valid_d    = pend_valid_q;
        pend_byte_d     = pend_byte_q;
        to_cnt_d        = to_cnt_q;
        ho_cnt_d        = ho_cnt_q;
        frame_dropped_d = 1'b0;
        overrun_d       = 1'b0;

        // Pending buffer: bytes that arrive while a frame is being replayed.
        // An error wins over a simultaneous byte and flushes the buffer.
        if (is_replay_state(state_q)) begin
            if (rx_error) begin
                pend_valid_d    = 1'b0;
                frame_dropped_d = 1'b1;
            end else if (rx_valid) begin
                if (pend_valid_q) begin
                    overrun_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_byte_d  = rx_data;
                end
            end
        end

        case (state_q)
            ST_WAIT_REQ: begin
                if (rx_valid && !rx_error) begin
                    req_d    = rx_data;
                    to_cnt_d = '0;
                    state_d  = ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                // A byte arriving on the expiry cycle still completes the frame.
                if (rx_error) begin
                    frame_dropped_d = 1'b1;
                    state_d         = ST_WAIT_REQ;
                end else if (rx_valid) begin
                    addr_d  = rx_data;
                    state_d = ST_ANNOUNCE;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_dropped_d = 1'b1;
                    state_d         = ST_WAIT_REQ;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_ANNOUNCE: state_d = ST_SEND_REQ;
            ST_SEND_REQ: state_d = ST_SEND_ADDR;
            ST_SEND_ADDR: begin
                ho_cnt_d = '0;
                state_d  = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (ho_cnt_q == HO_LAST) begin
                    // Uses the post-update buffer so a byte landing in the
                    // final holdoff cycle becomes the next request directly.
                    if (pend_valid_d) begin
                        req_d        = pend_byte_d;
                        pend_valid_d = 1'b0;
                        to_cnt_d     = '0;
                        state_d      = ST_WAIT_ADDR;
                    end else begin
                        state_d = ST_WAIT_REQ;
                    end
                end else begin
                    ho_cnt_d = ho_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT_REQ;
        endcase

        // Outputs are registered from the next state so they line up with it.
        enable_d = (state_d == ST_ANNOUNCE);
        busy_d   = is_replay_state(state_d);
        if (state_d == ST_SEND_REQ) begin
            received_data_d = req_q;
        end else if (state_d == ST_SEND_ADDR) begin
            received_data_d = addr_q;
        end else begin
            received_data_d = 8'h00;
        end
    end

    assign enable        = enable_q;
    assign received_data = received_data_q;
    assign busy          = busy_q;
    assign frame_dropped = frame_dropped_q;
    assign overrun       = overrun_q;
    assign debug_state   = state_q;

endmodule

// File: tb/tb_request_framer.sv
// tb/tb_request_framer.sv - self-checking bench for request_framer

module tb_request_framer;

    localparam int T = 1024;
    localparam int H = 2;

    bit         clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       enable;
    logic [7:0] received_data;
    logic       busy;
    logic       frame_dropped;
    logic       overrun;
    logic [2:0] debug_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    request_framer #(.TIMEOUT_CYCLES(T), .HOLDOFF_CYCLES(H)) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .enable(enable),
        .received_data(received_data),
        .busy(busy),
        .frame_dropped(frame_dropped),
        .overrun(overrun),
        .debug_state(debug_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a frame is described by the cycle its address byte arrived (f0);
    // every output is a function of the offset from that cycle.
    int         cyc = 0;
    bit         checking = 0;
    bit         have_req = 0;
    logic [7:0] m_req = 8'h00;
    int         req_t = 0;
    bit         pend_v = 0;
    logic [7:0] pend_b = 8'h00;
    int         f0 = -1000;
    logic [7:0] f_req = 8'h00, f_addr = 8'h00;
    bit         x_en = 0, x_busy = 0, x_drop = 0, x_ovr = 0;
    logic [7:0] x_data = 8'h00;
    logic [2:0] x_state = 3'd0;

    always @(negedge clock) begin
        bit n_drop, n_ovr;
        int off;
        if (checking) begin
            chk($sformatf("enable@%0d", cyc), enable, x_en);
            chk($sformatf("received_data@%0d", cyc), received_data, x_data);
            chk($sformatf("busy@%0d", cyc), busy, x_busy);
            chk($sformatf("frame_dropped@%0d", cyc), frame_dropped, x_drop);
            chk($sformatf("overrun@%0d", cyc), overrun, x_ovr);
            chk($sformatf("debug_state@%0d", cyc), debug_state, x_state);
        end
        n_drop = 0;
        n_ovr  = 0;
        if (reset === 1'b1) begin
            have_req = 0;
            pend_v   = 0;
            f0       = -1000;
            checking = 1;
        end else if (cyc >= f0 + 1 && cyc <= f0 + 3 + H) begin
            if (rx_error) begin
                pend_v = 0;
                n_drop = 1;
            end else if (rx_valid) begin
                if (pend_v) n_ovr = 1;
                else begin
                    pend_v = 1;
                    pend_b = rx_data;
                end
            end
            if (cyc == f0 + 3 + H && pend_v) begin
                have_req = 1;
                m_req    = pend_b;
                req_t    = cyc;
                pend_v   = 0;
            end
        end else if (have_req) begin
            if (rx_error) begin
                have_req = 0;
                n_drop   = 1;
            end else if (rx_valid) begin
                f0       = cyc;
                f_req    = m_req;
                f_addr   = rx_data;
                have_req = 0;
            end else if (cyc - req_t == T) begin
                have_req = 0;
                n_drop   = 1;
            end
        end else if (rx_valid && !rx_error) begin
            have_req = 1;
            m_req    = rx_data;
            req_t    = cyc;
        end
        off     = cyc + 1 - f0;
        x_en    = (off == 1);
        x_data  = (off == 2) ? f_req : (off == 3) ? f_addr : 8'h00;
        x_busy  = (off >= 1 && off <= 3 + H);
        x_state = (off == 1) ? 3'd2 : (off == 2) ? 3'd3 : (off == 3) ? 3'd4 :
                  (off >= 4 && off <= 3 + H) ? 3'd5 : (have_req ? 3'd1 : 3'd0);
        x_drop  = n_drop;
        x_ovr   = n_ovr;
        cyc++;
    end

    task automatic step(input logic r, input logic v, input logic e, input logic [7:0] d);
        reset    = r;
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    initial begin
        int k;
        @(posedge clock);
        #1;
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("reset_enable", enable, 1'b0);
        chk("reset_data", received_data, 8'h00);
        chk("reset_state", debug_state, 3'd0);
        idle(3);

        // Request and address 1000 cycles apart
        step(0, 1, 0, 8'h01);
        idle(999);
        step(0, 1, 0, 8'h20);
        chk("t1_enable", enable, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_state", debug_state, 3'd2);
        idle(1);
        chk("t1_req", received_data, 8'h01);
        idle(1);
        chk("t1_addr", received_data, 8'h20);
        idle(1);
        chk("t1_after", received_data, 8'h00);
        chk("t1_holdoff", debug_state, 3'd5);
        idle(4);

        // Lone request byte times out
        step(0, 1, 0, 8'h03);
        k = 1;
        while (frame_dropped !== 1'b1 && k < T + 100) begin
            idle(1);
            k++;
        end
        chk("t2_drop_delay", k, T + 1);
        chk("t2_state", debug_state, 3'd0);
        idle(3);

        // Address byte on the exact expiry cycle is accepted
        step(0, 1, 0, 8'h05);
        idle(T - 1);
        step(0, 1, 0, 8'h20);
        chk("t3_enable", enable, 1'b1);
        chk("t3_no_drop", frame_dropped, 1'b0);
        idle(1);
        chk("t3_req", received_data, 8'h05);
        idle(6);

        // Error with valid in WAIT_ADDR, then a clean frame
        step(0, 1, 0, 8'h01);
        idle(2);
        step(0, 1, 1, 8'h55);
        chk("t4_drop", frame_dropped, 1'b1);
        chk("t4_state", debug_state, 3'd0);
        idle(2);
        step(0, 1, 0, 8'h02);
        step(0, 1, 0, 8'h20);
        chk("t4_enable", enable, 1'b1);
        idle(1);
        chk("t4_req", received_data, 8'h02);
        idle(1);
        chk("t4_addr", received_data, 8'h20);
        idle(6);

        // Back-to-back frames: next request at C2, address at C6
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h20);
        idle(1);
        step(0, 1, 0, 8'h02);
        idle(3);
        step(0, 1, 0, 8'h20);
        chk("t5_enable_c7", enable, 1'b1);
        chk("t5_no_overrun", overrun, 1'b0);
        idle(1);
        chk("t5_req", received_data, 8'h02);
        idle(1);
        chk("t5_addr", received_data, 8'h20);
        idle(6);

        // Two bytes in holdoff: overrun, first one becomes the request
        step(0, 1, 0, 8'h07);
        step(0, 1, 0, 8'h20);
        idle(3);
        step(0, 1, 0, 8'h11);
        step(0, 1, 0, 8'h22);
        chk("t6_overrun", overrun, 1'b1);
        chk("t6_state", debug_state, 3'd1);
        step(0, 1, 0, 8'h20);
        chk("t6_enable", enable, 1'b1);
        idle(1);
        chk("t6_req", received_data, 8'h11);
        idle(6);

        // Error during holdoff
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h20);
        idle(3);
        step(0, 0, 1, 8'h00);
        chk("t7_drop", frame_dropped, 1'b1);
        chk("t7_busy", busy, 1'b1);
        idle(4);

        // Reset while in SEND_REQ
        step(0, 1, 0, 8'h09);
        step(0, 1, 0, 8'h20);
        idle(1);
        chk("t8_req", received_data, 8'h09);
        step(1, 0, 0, 8'h00);
        chk("t8_data", received_data, 8'h00);
        chk("t8_enable", enable, 1'b0);
        chk("t8_state", debug_state, 3'd0);
        chk("t8_busy", busy, 1'b0);
        idle(5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/request_framer.md
# request_framer

Upstream stage of the request decoder: collects the two-byte client request (request code, then sensor address) from the UART receiver's byte strobe and replays it in the fixed cycle pattern the request decoder consumes. The pattern is a one-cycle `enable` pulse, the request byte on the next cycle, then the address byte on the cycle after. The block discards incomplete or corrupted frames, guards against inter-byte stalls with a timeout, and enforces a holdoff so the decoder is back in IDLE before the next `enable`.

## Interface
- `TIMEOUT_CYCLES`, 100000: max cycles allowed between request byte and address byte.
- `HOLDOFF_CYCLES`, 2: idle cycles after the address byte before a new `enable` may be issued; must be ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- `rx_data`  in  8  byte from UART receiver; valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe, new byte on `rx_data`.
- `rx_error`  in  1  one-cycle strobe, framing/parity error on current byte.
- `enable`  out  1  one-cycle pulse announcing a frame to the decoder.
- `received_data`  out  8  request byte, then address byte, else 8'h00.
- `busy`  out  1  high from address acceptance through end of holdoff.
- `frame_dropped`  out  1  one-cycle pulse: partial frame discarded (error or timeout).
- `overrun`  out  1  one-cycle pulse: byte lost because pending buffer full.
- `debug_state`  out  3  current state encoding, registered.

## Operation
- States: WAIT_REQ(0), WAIT_ADDR(1), ANNOUNCE(2), SEND_REQ(3), SEND_ADDR(4), HOLDOFF(5).
- WAIT_REQ: on `rx_valid` (no `rx_error`), store byte in `req_q`, clear timeout counter, go WAIT_ADDR.
- WAIT_ADDR: on `rx_valid`, store byte in `addr_q`, go ANNOUNCE. On `rx_error`, pulse `frame_dropped`, go WAIT_REQ. When the counter reaches `TIMEOUT_CYCLES - 1` with no byte, pulse `frame_dropped`, go WAIT_REQ.
- ANNOUNCE: `enable`=1, `received_data`=0. SEND_REQ: `received_data`=`req_q`. SEND_ADDR: `received_data`=`addr_q`. Each state lasts one cycle.
- HOLDOFF: `HOLDOFF_CYCLES` cycles, `received_data`=0. Exit goes to WAIT_ADDR with `req_q`←pending byte if the pending buffer is full; otherwise exit goes to WAIT_REQ.
- Pending buffer: one byte. It captures `rx_valid` bytes arriving in ANNOUNCE, SEND_REQ, SEND_ADDR or HOLDOFF. A second byte while the buffer is full is dropped and pulses `overrun`. `rx_error` in those states clears the buffer and pulses `frame_dropped`.
- Simultaneous `rx_valid` and `rx_error`: error wins, byte discarded.
- `rx_valid` in the same cycle the timeout expires: byte accepted as address, no drop.
- Timeout counter width is clog2(`TIMEOUT_CYCLES`). It saturates and never wraps.

## Timing
- All outputs are registered.
- Reset values: `enable`=0, `received_data`=8'h00, `busy`=0, `frame_dropped`=0, `overrun`=0, `debug_state`=0. State = WAIT_REQ, pending buffer empty, `req_q`/`addr_q`=0.
- Reset mid-frame: outputs return to reset values on the cycle after the sampling edge. No `enable` pulse follows.
- Cycle C0 has `rx_valid` for the address byte. Then:
  - C1: `enable`=1.
  - C2: `received_data`=request.
  - C3: `received_data`=address.
  - C4 .. C(3+`HOLDOFF_CYCLES`): holdoff.
- With default holdoff, the earliest next `enable` is C7. This requires a pending request byte and an address byte in C6.
- `busy` is high C1 through the last holdoff cycle.
- `frame_dropped` and `overrun` are high exactly one cycle after the triggering edge.

## Structure
- Shared package `sensor_link_pkg`:
  - state encodings;
  - `HOLDOFF_MIN`=2;
  - DHT11 address constant 8'h20, shared with the decoder.
- No sub-modules. Timeout counter and pending buffer are inline. A single FSM plus datapath registers comes to roughly 150–250 lines.

## Test plan
- Bytes 8'h01 then 8'h20, 1000 cycles apart → `enable` 1 cycle after the second strobe; `received_data` 8'h01 then 8'h20 on the next two cycles; then 8'h00. Decoder `device_selected` pulses.
- Byte 8'h03, no second byte, `TIMEOUT_CYCLES`=16 → `frame_dropped` pulse 16 cycles later. No `enable`. `debug_state` back to 0.
- Byte 8'h01, then a strobe with `rx_valid`=`rx_error`=1 → `frame_dropped`, no `enable`. A following clean 8'h02, 8'h20 frame replays correctly.
- Back-to-back frames: 8'h01, 8'h20, then 8'h02 at C2 and 8'h20 at C6 → second `enable` at C7, second replay 8'h02/8'h20. No `overrun`.
- Two bytes during holdoff (C4, C5) after a full frame → `overrun` pulse at C6. First held byte used as the next request.
- `reset` asserted in SEND_REQ → `received_data`=0, `enable`=0, `debug_state`=0 the next cycle. No address byte is emitted.
